// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing the single PL-side port of axil_bram among N_REQ requesters.
// Define BRAM_ARB_LOCK_EN to add the req_lock input for exclusive multi-access grants.
module bram_port_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                        fpga_clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_we,
`ifdef BRAM_ARB_LOCK_EN
    input  logic [N_REQ-1:0]            req_lock,
`endif
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_din,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    output logic [DATA_WIDTH-1:0]       bram_din,
    output logic                        bram_we,
    input  logic [DATA_WIDTH-1:0]       bram_dout
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   sum_t;

    function automatic ptr_t next_ptr(input ptr_t cur);
        if (cur == ptr_t'(N_REQ - 1)) return '0;
        return ptr_t'(cur + 1'b1);
    endfunction

    ptr_t                  ptr_q, ptr_d;
    ptr_t                  arb_idx, grant_idx;
    logic [N_REQ-1:0]      arb_grant, grant;
    logic                  arb_found, hs, sel_we;
    sum_t                  scan_sum;
    logic [ADDR_WIDTH-1:0] sel_addr, bram_addr_q;
    logic [DATA_WIDTH-1:0] sel_din, bram_din_q, rsp_data_q;
    logic                  bram_we_q;
    logic [N_REQ-1:0]      rsp_valid_q;
    // Stage k holds the one-hot owner of the read issued k+1 cycles ago
    logic [N_REQ-1:0]      tag_q [READ_LATENCY+1];

`ifdef BRAM_ARB_LOCK_EN
    logic lock_q, lock_d;
    ptr_t lock_idx_q, lock_idx_d;
`endif

    always_comb begin
        arb_grant = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        scan_sum  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            scan_sum = {1'b0, ptr_q} + sum_t'(k);
            if (scan_sum >= sum_t'(N_REQ)) scan_sum = scan_sum - sum_t'(N_REQ);
            if (!arb_found && req_valid[scan_sum[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = scan_sum[PTR_W-1:0];
            end
        end
        if (arb_found) arb_grant[arb_idx] = 1'b1;
    end

    always_comb begin
        grant     = arb_grant;
        grant_idx = arb_idx;
`ifdef BRAM_ARB_LOCK_EN
        if (lock_q) begin
            grant     = '0;
            grant_idx = lock_idx_q;
            if (req_valid[lock_idx_q]) grant[lock_idx_q] = 1'b1;
        end
`endif
        // No handshake may happen while reset is asserted
        if (!rst_n) grant = '0;
    end

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign sel_we    = req_we[grant_idx];
    assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_din   = req_din[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        ptr_d = ptr_q;
        if (hs) ptr_d = next_ptr(grant_idx);
`ifdef BRAM_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (lock_q) begin
            if (!req_valid[lock_idx_q] || (hs && !req_lock[lock_idx_q])) begin
                lock_d = 1'b0;
                ptr_d  = next_ptr(lock_idx_q);
            end else begin
                ptr_d = ptr_q;
            end
        end else if (hs && req_lock[grant_idx]) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
            ptr_d      = ptr_q;
        end
`endif
    end

    always_ff @(posedge fpga_clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int i = 0; i <= int'(READ_LATENCY); i++) tag_q[i] <= '0;
`ifdef BRAM_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            bram_we_q <= hs & sel_we;
            if (hs) begin
                bram_addr_q <= sel_addr;
                bram_din_q  <= sel_din;
            end
            tag_q[0] <= (hs && !sel_we) ? grant : '0;
            for (int i = 1; i <= int'(READ_LATENCY); i++) tag_q[i] <= tag_q[i-1];
            rsp_valid_q <= tag_q[READ_LATENCY];
            if (|tag_q[READ_LATENCY]) rsp_data_q <= bram_dout;
`ifdef BRAM_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign bram_we   = bram_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 1-cycle-latency BRAM model on the PL port.
// Also covers the lock variant when BRAM_ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;

    logic         fpga_clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
    logic [39:0]  req_addr;
    logic [127:0] req_din;
    logic [31:0]  rsp_data, bram_din, bram_dout;
    logic [9:0]   bram_addr;
    logic         bram_we;
`ifdef BRAM_ARB_LOCK_EN
    logic [3:0]   req_lock;
`endif

    logic [31:0] mem [1024] = '{default: '0};

    int checks   = 0;
    int failures = 0;

    bram_port_arbiter #(
        .N_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)
    ) dut (
        .fpga_clk (fpga_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
`ifdef BRAM_ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .req_addr (req_addr),
        .req_din  (req_din),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_we  (bram_we),
        .bram_dout(bram_dout)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Read-first BRAM with one cycle from sampled address to dout
    always @(posedge fpga_clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [39:0] addr;
        logic [31:0] din0;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_data;
        logic        exp_we;
        logic [9:0]  exp_baddr;
        logic [31:0] exp_bdin;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w,
                                input logic [9:0] a3, input logic [9:0] a2,
                                input logic [9:0] a1, input logic [9:0] a0,
                                input logic [31:0] d0, input logic [3:0] er,
                                input logic [3:0] ersp, input logic [31:0] edata,
                                input logic ewe, input logic [9:0] eba, input logic [31:0] ebd);
        vec_t r;
        r.valid = v; r.we = w; r.addr = {a3, a2, a1, a0}; r.din0 = d0;
        r.exp_ready = er; r.exp_rsp = ersp; r.exp_data = edata;
        r.exp_we = ewe; r.exp_baddr = eba; r.exp_bdin = ebd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [39:0] a,
                         input logic [127:0] d);
        req_valid = v; req_we = w; req_addr = a; req_din = d;
    endtask

    task automatic step();
        @(posedge fpga_clk);
        #1;
    endtask

    logic [3:0] sb_valid [5];
    logic [3:0] sb_lock  [5];
    logic [3:0] sb_exp   [5];

    initial begin
        vecs[0]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0000, 0,            0, 0, 0);
        vecs[1]  = mk(4'b0001, 4'b0001, 0, 0, 0, 5, 32'hDEADBEEF, 4'b0001, 4'b0000, 0,            0, 0, 0);
        vecs[2]  = mk(4'b0001, 4'b0000, 0, 0, 0, 5, 0,            4'b0001, 4'b0000, 0,            1, 5, 32'hDEADBEEF);
        vecs[3]  = mk(4'b0001, 4'b0001, 0, 0, 0, 1, 32'h11,       4'b0001, 4'b0000, 0,            0, 0, 0);
        vecs[4]  = mk(4'b0001, 4'b0001, 0, 0, 0, 2, 32'h22,       4'b0001, 4'b0000, 0,            1, 1, 32'h11);
        vecs[5]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0001, 32'hDEADBEEF, 1, 2, 32'h22);
        vecs[6]  = mk(4'b0001, 4'b0000, 0, 0, 0, 1, 0,            4'b0001, 4'b0000, 0,            0, 0, 0);
        vecs[7]  = mk(4'b0100, 4'b0000, 0, 2, 0, 0, 0,            4'b0100, 4'b0000, 0,            0, 0, 0);
        vecs[8]  = mk(4'b1000, 4'b0000, 0, 0, 0, 0, 0,            4'b1000, 4'b0000, 0,            0, 0, 0);
        vecs[9]  = mk(4'b1111, 4'b0000, 0, 2, 5, 1, 0,            4'b0001, 4'b0001, 32'h11,       0, 0, 0);
        vecs[10] = mk(4'b1111, 4'b0000, 0, 2, 5, 1, 0,            4'b0010, 4'b0100, 32'h22,       0, 0, 0);
        vecs[11] = mk(4'b1111, 4'b0000, 0, 2, 5, 1, 0,            4'b0100, 4'b1000, 32'h0,        0, 0, 0);
        vecs[12] = mk(4'b1111, 4'b0000, 0, 2, 5, 1, 0,            4'b1000, 4'b0001, 32'h11,       0, 0, 0);
        vecs[13] = mk(4'b1111, 4'b0000, 0, 2, 5, 1, 0,            4'b0001, 4'b0010, 32'hDEADBEEF, 0, 0, 0);
        vecs[14] = mk(4'b0010, 4'b0000, 0, 0, 2, 0, 0,            4'b0010, 4'b0100, 32'h22,       0, 0, 0);
        vecs[15] = mk(4'b1010, 4'b0000, 5, 0, 1, 0, 0,            4'b1000, 4'b1000, 32'h0,        0, 0, 0);
        vecs[16] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 0,            4'b0010, 4'b0001, 32'h11,       0, 0, 0);
        vecs[17] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0010, 32'h22,       0, 0, 0);
        vecs[18] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b1000, 32'hDEADBEEF, 0, 0, 0);
        vecs[19] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0010, 32'h11,       0, 0, 0);
        vecs[20] = mk(4'b0101, 4'b0000, 0, 1, 0, 2, 0,            4'b0100, 4'b0000, 0,            0, 0, 0);
        vecs[21] = mk(4'b0001, 4'b0000, 0, 0, 0, 2, 0,            4'b0001, 4'b0000, 0,            0, 0, 0);
        vecs[22] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0000, 0,            0, 0, 0);
        vecs[23] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0100, 32'h11,       0, 0, 0);
        vecs[24] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0,            4'b0000, 4'b0001, 32'h22,       0, 0, 0);

`ifdef BRAM_ARB_LOCK_EN
        sb_valid = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010};
        sb_lock  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        sb_exp   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
        req_lock = 4'b0000;
`else
        sb_valid = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
        sb_lock  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        sb_exp   = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif

        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, '0, '0);
        step();
        step();
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data", rsp_data, 32'h0);
        check("reset bram_addr", 32'(bram_addr), 32'h0);
        check("reset bram_din", bram_din, 32'h0);
        check("reset bram_we", 32'(bram_we), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].addr, {96'd0, vecs[i].din0});
            @(negedge fpga_clk);
            check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp));
            check($sformatf("v%0d bram_we", i), 32'(bram_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_rsp != 4'b0000)
                check($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].exp_data);
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d bram_addr", i), 32'(bram_addr), 32'(vecs[i].exp_baddr));
                check($sformatf("v%0d bram_din", i), bram_din, vecs[i].exp_bdin);
            end
            step();
        end

        // Two reads in flight, then a one-cycle reset with all requesters still asserting valid
        drive(4'b0010, 4'b0000, {10'd0, 10'd0, 10'd5, 10'd0}, '0);
        @(negedge fpga_clk);
        check("inflight a req_ready", 32'(req_ready), 32'h2);
        step();
        drive(4'b0100, 4'b0000, {10'd0, 10'd2, 10'd0, 10'd0}, '0);
        @(negedge fpga_clk);
        check("inflight b req_ready", 32'(req_ready), 32'h4);
        step();
        rst_n = 1'b0;
        drive(4'b1111, 4'b0000, '0, '0);
        @(negedge fpga_clk);
        check("in-reset req_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, '0, '0);
        @(negedge fpga_clk);
        check("post-reset rsp_data", rsp_data, 32'h0);
        check("post-reset bram_addr", 32'(bram_addr), 32'h0);
        check("post-reset bram_din", bram_din, 32'h0);
        check("post-reset bram_we", 32'(bram_we), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge fpga_clk);
            check($sformatf("post-reset rsp_valid %0d", i), 32'(rsp_valid), 32'h0);
            step();
        end
        drive(4'b1111, 4'b1111, '0, '0);
        @(negedge fpga_clk);
        check("post-reset first grant", 32'(req_ready), 32'h1);
        step();
        drive(4'b1000, 4'b1000, '0, '0);
        @(negedge fpga_clk);
        check("req3 grant from p=1", 32'(req_ready), 32'h8);
        step();

        // req0 issues three writes while req1 competes
        for (int i = 0; i < 5; i++) begin
            drive(sb_valid[i], 4'b0011, {10'd0, 10'd0, 10'd11, 10'd10},
                  {64'd0, 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
`ifdef BRAM_ARB_LOCK_EN
            req_lock = sb_lock[i];
`endif
            @(negedge fpga_clk);
            check($sformatf("contend c%0d req_ready", i), 32'(req_ready), 32'(sb_exp[i]));
            step();
        end
        drive(4'b0000, 4'b0000, '0, '0);
`ifdef BRAM_ARB_LOCK_EN
        req_lock = 4'b0000;
`endif
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
